// File: rtl/fixed_point_adder_pipe.sv
// Two-stage streaming fixed-point adder/subtractor: stage 1 aligns and adds exactly,
// stage 2 requantises to format C with selectable rounding and overflow handling.
module fixed_point_adder_pipe #(
    parameter int A_FRAC_LEN = 8,
    parameter int A_WORD_LEN = 9,
    parameter int B_FRAC_LEN = 8,
    parameter int B_WORD_LEN = 9,
    parameter int C_FRAC_LEN = 8,
    parameter int C_WORD_LEN = 10,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WORD_LEN-1:0] a,
    input  logic [B_WORD_LEN-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [C_WORD_LEN-1:0] c,
    output logic                  ovf,
    input  logic                  clr_sticky,
    output logic                  ovf_sticky
);

    localparam int A_INT = A_WORD_LEN - A_FRAC_LEN;
    localparam int B_INT = B_WORD_LEN - B_FRAC_LEN;
    localparam int F     = (A_FRAC_LEN > B_FRAC_LEN) ? A_FRAC_LEN : B_FRAC_LEN;
    localparam int I     = ((A_INT > B_INT) ? A_INT : B_INT) + 1;
    localparam int W     = I + F;
    localparam int A_SH  = F - A_FRAC_LEN;
    localparam int B_SH  = F - B_FRAC_LEN;
    localparam int UP    = (C_FRAC_LEN >= F) ? (C_FRAC_LEN - F) : 0;
    localparam int DN    = (C_FRAC_LEN < F) ? (F - C_FRAC_LEN) : 0;
    // Wide enough for the upshifted sum, the rounding carry and a clean compare against the C range.
    localparam int QW    = W + UP + C_WORD_LEN + 2;

    logic                  s1_valid_q;
    logic signed [W-1:0]   sum_q;
    logic                  out_valid_q;
    logic [C_WORD_LEN-1:0] c_q;
    logic                  ovf_q;
    logic                  sticky_q;

    logic                  s1_load;
    logic                  s2_load;

    logic signed [W-1:0]   a_ext;
    logic signed [W-1:0]   b_ext;
    logic signed [W-1:0]   sum_d;

    logic signed [QW-1:0]  sum_wide;
    logic signed [QW-1:0]  q_val;
    logic signed [QW-1:0]  c_max;
    logic signed [QW-1:0]  c_min;
    logic                  ovf_d;
    logic [C_WORD_LEN-1:0] c_d;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    assign a_ext = $signed({{(W-A_WORD_LEN){a[A_WORD_LEN-1]}}, a}) <<< A_SH;
    assign b_ext = $signed({{(W-B_WORD_LEN){b[B_WORD_LEN-1]}}, b}) <<< B_SH;
    assign sum_d = sub ? (a_ext - b_ext) : (a_ext + b_ext);

    assign sum_wide = {{(QW-W){sum_q[W-1]}}, sum_q};

    generate
        if (DN == 0) begin : g_up
            assign q_val = sum_wide <<< UP;
        end else begin : g_dn
            logic signed [QW-1:0] half;
            assign half  = (ROUND != 0) ? ($signed({{(QW-1){1'b0}}, 1'b1}) <<< (DN - 1)) : '0;
            assign q_val = (sum_wide + half) >>> DN;
        end
    endgenerate

    assign c_max = {{(QW-C_WORD_LEN+1){1'b0}}, {(C_WORD_LEN-1){1'b1}}};
    assign c_min = {{(QW-C_WORD_LEN+1){1'b1}}, {(C_WORD_LEN-1){1'b0}}};
    assign ovf_d = (q_val > c_max) || (q_val < c_min);

    always_comb begin
        c_d = q_val[C_WORD_LEN-1:0];
        if (ovf_d && (SATURATE != 0)) begin
            c_d = q_val[QW-1] ? c_min[C_WORD_LEN-1:0] : c_max[C_WORD_LEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    sum_q <= sum_d;
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    c_q   <= c_d;
                    ovf_q <= ovf_d;
                end
            end
            // A new overflow beats a simultaneous clear so no event is lost.
            if (s2_load && s1_valid_q && ovf_d) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign c          = c_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule
